mul_scheduler: RTL

Shared-multiplier scheduler for the 8-bit calculator: arbitrates two requesters (e.g. keypad-driven operation path and the repeat/accumulate path) onto a single iterative shift-add multiply engine. Accepts one operand pair at a time over a valid/ready handshake and runs the engine for exactly N cycles. Returns an N-bit product, the requester ID and an out-of-range flag, held until the consumer accepts. Replaces direct instantiation of a combinational `in1*in2` with a fixed-latency, shareable resource.

---
 rtl/mul_sched_pkg.sv | 15 +
 rtl/mul_shift_add_core.sv | 46 ++++
 rtl/mul_scheduler.sv | 93 +++++++++
 3 files changed

// File: rtl/mul_sched_pkg.sv
// Shared types and constants for the shared-multiplier scheduler.
package mul_sched_pkg;

  localparam int unsigned MUL_N = 8;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mul_shift_add_core.sv
// Iterative shift-add multiplier datapath: one partial-product step per cycle.
module mul_shift_add_core
  import mul_sched_pkg::*;
#(
  parameter int unsigned N = MUL_N
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic           step,
  input  logic [N-1:0]   a_in,
  input  logic [N-1:0]   b_in,
  output logic [2*N-1:0] acc,
  output logic           last
);

  localparam int unsigned AW = 2 * N;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  logic [AW-1:0] a_q;
  logic [N-1:0]  b_q;
  logic [CW-1:0] cnt_q;

  // The 2N-bit accumulator cannot carry out: the full product fits in 2N bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      acc   <= '0;
      cnt_q <= '0;
    end else if (load) begin
      a_q   <= AW'(a_in);
      b_q   <= b_in;
      acc   <= '0;
      cnt_q <= '0;
    end else if (step) begin
      if (b_q[0]) acc <= acc + a_q;
      a_q   <= a_q << 1;
      b_q   <= b_q >> 1;
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign last = (cnt_q == CW'(N - 1));

endmodule

// File: rtl/mul_scheduler.sv
// Round-robin arbiter and response holder in front of one shift-add multiplier.
module mul_scheduler
  import mul_sched_pkg::*;
#(
  parameter int unsigned N = MUL_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  output logic         req1_ready,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic         resp_id,
  output logic [N-1:0] resp_product,
  output logic         resp_overflow,
  output logic         busy
);

  state_t         state_q, state_next;
  logic           ptr_q;
  logic           id_q;
  logic           grant1;
  logic           load;
  logic           step;
  logic           last;
  logic [2*N-1:0] acc;

  // On a tie, serve whichever requester was not served last.
  assign grant1 = (req0_valid && req1_valid) ? ~ptr_q : req1_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= REQ1;
      id_q    <= REQ0;
    end else begin
      state_q <= state_next;
      if (load) id_q <= grant1;
      if (state_q == DONE && resp_ready) ptr_q <= id_q;
    end
  end

  always_comb begin
    state_next = state_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    load       = 1'b0;
    step       = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          req0_ready = ~grant1;
          req1_ready = grant1;
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) state_next = DONE;
      end
      DONE: begin
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  mul_shift_add_core #(.N(N)) u_core (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .step (step),
    .a_in (grant1 ? req1_a : req0_a),
    .b_in (grant1 ? req1_b : req0_b),
    .acc  (acc),
    .last (last)
  );

  // The accumulator is frozen in DONE, so the response fields are stable under back-pressure.
  assign resp_valid    = (state_q == DONE);
  assign resp_id       = id_q;
  assign resp_product  = acc[N-1:0];
  assign resp_overflow = |acc[2*N-1:N];
  assign busy          = (state_q != IDLE);

endmodule
